// File: rtl/bch_pkg.sv
// Shared limits, FSM encoding and operand legality check for the BCH encoder.
package bch_pkg;

    localparam int N_MAX = 1023;
    localparam int T_MAX = 4;
    localparam int M_MAX = 10;
    localparam int R_MAX = T_MAX * M_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // A request is usable only if the parity fits the limits and leaves k >= 1 message bits.
    function automatic logic params_legal(input logic [9:0] n,
                                          input logic [3:0] t,
                                          input logic [3:0] m,
                                          input int         n_max,
                                          input int         t_max,
                                          input int         m_max);
        int r;
        r = int'(m) * int'(t);
        return (t != 4'd0) && (int'(t) <= t_max) &&
               (int'(m) >= 3) && (int'(m) <= m_max) &&
               (int'(n) <= n_max) && (int'(n) > r);
    endfunction

endpackage

// File: rtl/bch_lfsr.sv
// Variable-length Galois LFSR dividing the shifted message by the generator polynomial.
// Latency: one message bit folded per enabled cycle; par updates on the same edge.
// Backpressure: none; the controller gates progress through en.
module bch_lfsr #(
    parameter  int R_MAX = bch_pkg::R_MAX,
    localparam int RW    = $clog2(R_MAX + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    input  logic [R_MAX-1:0] taps,
    input  logic [RW-1:0]    r,
    output logic [R_MAX-1:0] par
);

    localparam logic [R_MAX-1:0] ONE = {{(R_MAX-1){1'b0}}, 1'b1};

    logic [R_MAX-1:0] mask;
    logic [R_MAX-1:0] par_nxt;
    logic             fb;

    // Wraps to all ones when r == R_MAX.
    assign mask    = (ONE << r) - ONE;
    assign fb      = din ^ par[r - RW'(1)];
    assign par_nxt = ((par << 1) ^ (fb ? taps : '0)) & mask;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            par <= '0;
        end else if (clr) begin
            par <= '0;
        end else if (en) begin
            par <= par_nxt;
        end
    end

endmodule

// File: rtl/bch_encoder.sv
// Systematic BCH encoder: serial LFSR division, parity in low r bits, message above it.
// Latency: done k+1 cycles after the start edge (1 cycle for illegal operands).
// Backpressure: start is ignored while busy; results hold until the next accepted start.
module bch_encoder #(
    parameter  int N_MAX = bch_pkg::N_MAX,
    parameter  int T_MAX = bch_pkg::T_MAX,
    parameter  int M_MAX = bch_pkg::M_MAX,
    localparam int R_MAX = T_MAX * M_MAX
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [9:0]       n,
    input  logic [3:0]       t,
    input  logic [3:0]       m,
    input  logic [R_MAX:0]   gen_poly,
    input  logic [N_MAX-1:0] msg_bits,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [N_MAX-1:0] codeword
);
    import bch_pkg::*;

    localparam int RW = $clog2(R_MAX + 1);
    localparam logic [N_MAX-1:0] ONE_N = {{(N_MAX-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [9:0]       n_q, cnt;
    logic [RW-1:0]    r_q;
    logic [N_MAX-1:0] msg_q;
    logic [R_MAX-1:0] taps_q;
    logic             ill_q, done_q, err_q;
    logic [N_MAX-1:0] cw_q;

    logic [7:0]       r_in;
    logic [9:0]       k_in, k_q;
    logic             legal_in, accept;
    logic [R_MAX-1:0] par;
    logic [N_MAX-1:0] msg_mask, cw_asm;
    logic             unused_bits;

    assign r_in     = {4'd0, m} * {4'd0, t};
    assign legal_in = params_legal(n, t, m, N_MAX, T_MAX, M_MAX);
    assign k_in     = n - {2'b00, r_in};
    // The done cycle still counts as busy so a start there cannot slip in.
    assign busy     = (state != IDLE) || done_q;
    assign accept   = start && (state == IDLE) && !done_q;
    assign unused_bits = ^{gen_poly[R_MAX], r_in};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = legal_in ? ENC : FIN;
            ENC:     if (cnt == 10'd0) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    bch_lfsr #(.R_MAX(R_MAX)) u_lfsr (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept),
        .en   (state == ENC),
        .din  (msg_q[cnt]),
        .taps (taps_q),
        .r    (r_q),
        .par  (par)
    );

    assign k_q      = n_q - {{(10-RW){1'b0}}, r_q};
    assign msg_mask = (ONE_N << k_q) - ONE_N;
    assign cw_asm   = ((msg_q & msg_mask) << r_q) | {{(N_MAX-R_MAX){1'b0}}, par};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            n_q    <= '0;
            r_q    <= '0;
            msg_q  <= '0;
            taps_q <= '0;
            cnt    <= '0;
            ill_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cw_q   <= '0;
        end else begin
            done_q <= (state == FIN);
            if (accept) begin
                n_q    <= n;
                r_q    <= r_in[RW-1:0];
                msg_q  <= msg_bits;
                taps_q <= gen_poly[R_MAX-1:0];
                cnt    <= k_in - 10'd1;
                ill_q  <= !legal_in;
                if (legal_in) err_q <= 1'b0;
            end else if (state == ENC) begin
                cnt <= cnt - 10'd1;
            end
            if (state == FIN) begin
                err_q <= ill_q;
                cw_q  <= ill_q ? '0 : cw_asm;
            end
        end
    end

    assign done     = done_q;
    assign err      = err_q;
    assign codeword = cw_q;

endmodule

// File: doc/bch_encoder.md
BCH_ENCODER -- requirements
Module: bch_encoder

Interface
REQ-001 Parameter N_MAX, default 1023: maximum codeword length n.
REQ-002 Parameter T_MAX, default 4: maximum correctable errors t.
REQ-003 Parameter M_MAX, default 10: maximum field degree m; R_MAX = T_MAX*M_MAX = 40.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle request; operands sampled on the same edge.
REQ-007 n  in  10  codeword length.
REQ-008 t  in  4  error capability.
REQ-009 m  in  4  field degree; parity length r = m*t.
REQ-010 gen_poly  in  R_MAX+1  generator polynomial, bit i = coefficient of x^i; bit r and bit 0 shall be 1.
REQ-011 msg_bits  in  N_MAX  message, bit j = coefficient of x^(j+r); only bits [k-1:0] used, k = n-r.
REQ-012 busy  out  1  high from the cycle after accepted start through the done cycle.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 err  out  1  high with done when parameters are illegal.
REQ-015 codeword  out  N_MAX  systematic codeword, bit i = coefficient of x^i.

Function
REQ-016 FSM states IDLE, ENC, FIN; reset state IDLE.
REQ-017 IDLE + start: latch n, t, m, gen_poly, msg_bits; clear parity register par[R_MAX-1:0]; bit counter = k-1; go to ENC (or FIN if illegal).
REQ-018 start while busy is ignored; latched operands are not disturbed.
REQ-019 Illegal = t==0, t>T_MAX, m<3, m>M_MAX, n>N_MAX, or n<=r; -> FIN with err=1, codeword all zero.
REQ-020 ENC: one message bit per cycle, highest index first (msg bit k-1 first, bit 0 last).
REQ-021 LFSR step: fb = msg_bit XOR par[r-1]; par = ((par<<1) masked to r bits) XOR (fb ? gen_poly[r-1:0] : 0); par bits >= r forced to 0.
REQ-022 Counter decrements each ENC cycle; after processing bit 0, go to FIN.
REQ-023 FIN: done=1 for exactly one cycle; codeword[r-1:0]=par[r-1:0], codeword[n-1:r]=msg[k-1:0], codeword[N_MAX-1:n]=0; next state IDLE.
REQ-024 Latency: done high in the cycle after the (k+1)-th rising edge following the start-sampling edge; illegal case: cycle after the 1st edge.
REQ-025 codeword and err hold their values until the next accepted start updates them; err cleared on next legal start.
REQ-026 k=1 boundary: one ENC cycle, done after 2 edges.
REQ-027 start coincident with FIN cycle is ignored (busy=1).

Reset
REQ-028 rstn=0 at an edge: state IDLE, busy=0, done=0, err=0, codeword=0, par=0, counter=0.
REQ-029 Reset mid-ENC aborts the operation; no done pulse is produced for it.

Structure
REQ-030 Package bch_pkg: N_MAX, T_MAX, M_MAX, R_MAX constants, FSM state enum, legality-check function.
REQ-031 One sub-module bch_lfsr: variable-length (r <= R_MAX) Galois LFSR with clear, enable, data bit, gen taps, r input; FSM and output assembly in bch_encoder.

Verification
REQ-032 BCH(15,7): n=15,t=2,m=4,gen_poly=0x1D1,msg=7'h01, start -> done 8 cycles later, codeword=15'h01D1, err=0.
REQ-033 Same params, msg=7'h7F -> codeword=15'h7FFF; msg=0 -> codeword=0.
REQ-034 t=0 (or n=8,m=4,t=2 so n<=r) -> done+err one cycle after start, codeword=0, busy low afterwards.
REQ-035 Second start pulsed 3 cycles after first accepted start -> ignored; single done, codeword of first request.
REQ-036 rstn low for one cycle during ENC -> no done, all outputs 0; subsequent start completes normally.
REQ-037 Random legal (n,t,m,g,msg) vs reference model: codeword mod g == 0 and message field intact.
